// File: rtl/card_reveal_ctrl.sv
// card_reveal_ctrl: turn controller for the 16-card memory-pairs game.
// Accepts card selections, shows the chosen cards, compares each pair,
// locks matches and holds mismatches visible for SHOW_CYCLES before
// flipping them back.
// Optional feature macro: CARD_ATTEMPT_COUNT_EN adds the 8-bit saturating
// `attempts` output, which counts compares since the last reset.
module card_reveal_ctrl #(
  parameter int N_CARDS     = 16,
  parameter int SHOW_CYCLES = 25_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sel_valid,
  input  logic [3:0]             sel_idx,
  input  logic [4*N_CARDS-1:0]   board_values,
  output logic [N_CARDS-1:0]     face_up,
  output logic [N_CARDS-1:0]     matched,
  output logic [7:0]             selected1,
  output logic [7:0]             selected2,
  output logic                   par,
  output logic                   match_pulse,
  output logic                   mismatch_pulse,
  output logic                   busy,
  output logic [3:0]             pairs_found,
`ifdef CARD_ATTEMPT_COUNT_EN
  output logic [7:0]             attempts,
`endif
  output logic                   game_done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ONE  = 3'd1,
    ST_CMP  = 3'd2,
    ST_SHOW = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Counter reload: the SHOW state lasts exactly SHOW_CYCLES cycles.
  localparam logic [25:0] SHOW_LOAD = 26'(SHOW_CYCLES - 1);

  state_t               state_q, state_d;
  logic [25:0]          cnt_q, cnt_d;
  logic [N_CARDS-1:0]   face_up_q, face_up_d;
  logic [N_CARDS-1:0]   matched_q, matched_d;
  logic [7:0]           sel1_q, sel1_d;
  logic [7:0]           sel2_q, sel2_d;
  logic                 par_q, par_d;
  logic                 match_pulse_q, match_pulse_d;
  logic                 mismatch_pulse_q, mismatch_pulse_d;
  logic                 busy_q, busy_d;
  logic [3:0]           pairs_q, pairs_d;
  logic                 done_q, done_d;
  logic                 sel_ok;
  logic [3:0]           sym1, sym2;
`ifdef CARD_ATTEMPT_COUNT_EN
  logic [7:0]           attempts_q, attempts_d;
`endif

  // Next-state and next-output computation for the reveal sequence.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    face_up_d        = face_up_q;
    matched_d        = matched_q;
    sel1_d           = sel1_q;
    sel2_d           = sel2_q;
    par_d            = par_q;
    match_pulse_d    = 1'b0;
    mismatch_pulse_d = 1'b0;
    pairs_d          = pairs_q;
    done_d           = done_q;
`ifdef CARD_ATTEMPT_COUNT_EN
    attempts_d       = attempts_q;
`endif
    // A card can be picked only while it is hidden and not yet locked.
    sel_ok = sel_valid && !face_up_q[sel_idx] && !matched_q[sel_idx];
    sym1   = board_values[{sel1_q[3:0], 2'b00} +: 4];
    sym2   = board_values[{sel2_q[3:0], 2'b00} +: 4];

    case (state_q)
      ST_IDLE: begin
        if (sel_ok) begin
          face_up_d[sel_idx] = 1'b1;
          sel1_d             = {4'h0, sel_idx};
          sel2_d             = 8'hFF;
          state_d            = ST_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ONE: begin
        if (sel_ok) begin
          face_up_d[sel_idx] = 1'b1;
          sel2_d             = {4'h0, sel_idx};
          state_d            = ST_CMP;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_CMP: begin
`ifdef CARD_ATTEMPT_COUNT_EN
        if (attempts_q != 8'hFF) begin
          attempts_d = attempts_q + 8'd1;
        end else begin
          attempts_d = attempts_q;
        end
`endif
        if (sym1 == sym2) begin
          matched_d[sel1_q[3:0]] = 1'b1;
          matched_d[sel2_q[3:0]] = 1'b1;
          match_pulse_d          = 1'b1;
          if (pairs_q < 4'd8) begin
            pairs_d = pairs_q + 4'd1;
          end else begin
            pairs_d = pairs_q;
          end
          if (pairs_q == 4'd7) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          mismatch_pulse_d = 1'b1;
          par_d            = 1'b1;
          cnt_d            = SHOW_LOAD;
          state_d          = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (cnt_q == 26'd0) begin
          face_up_d[sel1_q[3:0]] = 1'b0;
          face_up_d[sel2_q[3:0]] = 1'b0;
          par_d                  = 1'b0;
          state_d                = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 26'd1;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_CMP) || (state_d == ST_SHOW);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      cnt_q            <= 26'd0;
      face_up_q        <= '0;
      matched_q        <= '0;
      sel1_q           <= 8'hFF;
      sel2_q           <= 8'hFF;
      par_q            <= 1'b0;
      match_pulse_q    <= 1'b0;
      mismatch_pulse_q <= 1'b0;
      busy_q           <= 1'b0;
      pairs_q          <= 4'd0;
      done_q           <= 1'b0;
`ifdef CARD_ATTEMPT_COUNT_EN
      attempts_q       <= 8'd0;
`endif
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      face_up_q        <= face_up_d;
      matched_q        <= matched_d;
      sel1_q           <= sel1_d;
      sel2_q           <= sel2_d;
      par_q            <= par_d;
      match_pulse_q    <= match_pulse_d;
      mismatch_pulse_q <= mismatch_pulse_d;
      busy_q           <= busy_d;
      pairs_q          <= pairs_d;
      done_q           <= done_d;
`ifdef CARD_ATTEMPT_COUNT_EN
      attempts_q       <= attempts_d;
`endif
    end
  end

  assign face_up        = face_up_q;
  assign matched        = matched_q;
  assign selected1      = sel1_q;
  assign selected2      = sel2_q;
  assign par            = par_q;
  assign match_pulse    = match_pulse_q;
  assign mismatch_pulse = mismatch_pulse_q;
  assign busy           = busy_q;
  assign pairs_found    = pairs_q;
  assign game_done      = done_q;
`ifdef CARD_ATTEMPT_COUNT_EN
  assign attempts       = attempts_q;
`endif

endmodule
